// File: rtl/vec3_length_unit.sv
// Iterative fixed-point vec3 length: shared-multiplier sum of squares, then restoring sqrt.
// Define VEC3_LEN_SQ_OUT_EN to add the out_len_sq port (squared length in Q(FRAC_BITS)).
module vec3_length_unit #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned FRAC_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_x,
    input  logic [WORD_WIDTH-1:0] in_y,
    input  logic [WORD_WIDTH-1:0] in_z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_len,
    output logic                  out_sat
`ifdef VEC3_LEN_SQ_OUT_EN
    ,
    output logic [WORD_WIDTH-1:0] out_len_sq
`endif
);

    localparam int unsigned AccW  = 2 * WORD_WIDTH;
    localparam int unsigned RemW  = WORD_WIDTH + 2;
    localparam int unsigned RootW = WORD_WIDTH + 1;
    localparam int unsigned CntW  = $clog2(WORD_WIDTH);

    localparam logic [CntW-1:0]       LastMac  = CntW'(2);
    localparam logic [CntW-1:0]       LastIter = CntW'(WORD_WIDTH - 1);
    localparam logic [WORD_WIDTH-1:0] MaxPos   = {1'b0, {(WORD_WIDTH - 1){1'b1}}};

    typedef enum logic [1:0] {StIdle, StMac, StSqrt, StDone} state_e;

    state_e                state_q;
    logic [WORD_WIDTH-1:0] x_q, y_q, z_q;
    logic [AccW-1:0]       acc_q;
    logic [AccW-1:0]       rad_q;
    logic [RemW-1:0]       rem_q;
    logic [RootW-1:0]      root_q;
    logic [CntW-1:0]       cnt_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [WORD_WIDTH-1:0] out_len_q;
    logic                  out_sat_q;

    logic [WORD_WIDTH-1:0]  comp;
    logic signed [AccW-1:0] comp_ext;
    logic signed [AccW-1:0] sq;
    logic [AccW-1:0]        acc_sum;
    logic [RemW:0]          rem_sh;
    logic [RemW:0]          trial;
    logic [RemW-1:0]        rem_nxt;
    logic [RootW-1:0]       root_nxt;
    logic                   root_ovf;

    always_comb begin
        comp = z_q;
        if (cnt_q == CntW'(0)) begin
            comp = x_q;
        end else if (cnt_q == CntW'(1)) begin
            comp = y_q;
        end
        comp_ext = {{WORD_WIDTH{comp[WORD_WIDTH-1]}}, comp};
        sq       = comp_ext * comp_ext;
        acc_sum  = acc_q + $unsigned(sq);
    end

    // One restoring step: bring down the next radicand bit pair, try root*4+1.
    always_comb begin
        rem_sh = {rem_q, rad_q[AccW-1 -: 2]};
        trial  = {root_q, 2'b01};
        if (rem_sh >= trial) begin
            rem_nxt  = RemW'(rem_sh - trial);
            root_nxt = {root_q[RootW-2:0], 1'b1};
        end else begin
            rem_nxt  = rem_sh[RemW-1:0];
            root_nxt = {root_q[RootW-2:0], 1'b0};
        end
        root_ovf = |root_nxt[RootW-1:WORD_WIDTH-1];
    end

`ifdef VEC3_LEN_SQ_OUT_EN
    logic [WORD_WIDTH-1:0] len_sq_q;
    logic [WORD_WIDTH-1:0] out_len_sq_q;
    logic [WORD_WIDTH-1:0] len_sq_nxt;

    always_comb begin
        if (|acc_sum[AccW-1:FRAC_BITS+WORD_WIDTH-1]) begin
            len_sq_nxt = MaxPos;
        end else begin
            len_sq_nxt = {1'b0, acc_sum[FRAC_BITS+WORD_WIDTH-2:FRAC_BITS]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_sq_q     <= '0;
            out_len_sq_q <= '0;
        end else begin
            if (state_q == StMac && cnt_q == LastMac) begin
                len_sq_q <= len_sq_nxt;
            end
            if (state_q == StSqrt && cnt_q == LastIter) begin
                out_len_sq_q <= len_sq_q;
            end
        end
    end

    assign out_len_sq = out_len_sq_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            acc_q       <= '0;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_len_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        x_q        <= in_x;
                        y_q        <= in_y;
                        z_q        <= in_z;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == LastMac) begin
                        rad_q   <= acc_sum;
                        rem_q   <= '0;
                        root_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= StSqrt;
                    end
                end
                StSqrt: begin
                    rad_q  <= {rad_q[AccW-3:0], 2'b00};
                    rem_q  <= rem_nxt;
                    root_q <= root_nxt;
                    cnt_q  <= cnt_q + CntW'(1);
                    if (cnt_q == LastIter) begin
                        out_valid_q <= 1'b1;
                        out_sat_q   <= root_ovf;
                        out_len_q   <= root_ovf ? MaxPos : root_nxt[WORD_WIDTH-1:0];
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_len   = out_len_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_vec3_length_unit.sv
// Bench for vec3_length_unit: directed and random vectors against an arithmetic length model.
module tb_vec3_length_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x, in_y, in_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_len;
    logic        out_sat;
`ifdef VEC3_LEN_SQ_OUT_EN
    logic [31:0] out_len_sq;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    vec3_length_unit #(
        .WORD_WIDTH(32),
        .FRAC_BITS (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_z     (in_z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_len  (out_len),
        .out_sat  (out_sat)
`ifdef VEC3_LEN_SQ_OUT_EN
        ,
        .out_len_sq(out_len_sq)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Length from first principles: sum of squares, then the largest r with r*r <= N.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         output logic [31:0] len, output logic sat, output logic [31:0] lsq);
        logic [127:0] n;
        logic [127:0] r;
        logic [127:0] cand;
        logic [127:0] nsh;
        longint       c [3];
        c[0] = longint'($signed(x));
        c[1] = longint'($signed(y));
        c[2] = longint'($signed(z));
        n = '0;
        for (int i = 0; i < 3; i++) begin
            n = n + {64'b0, 64'(c[i] * c[i])};
        end
        r = '0;
        for (int b = 34; b >= 0; b--) begin
            cand = r | (128'd1 << b);
            if (cand * cand <= n) r = cand;
        end
        if (r > 128'h7FFF_FFFF) begin
            len = 32'h7FFF_FFFF;
            sat = 1'b1;
        end else begin
            len = r[31:0];
            sat = 1'b0;
        end
        nsh = n >> 16;
        lsq = (nsh > 128'h7FFF_FFFF) ? 32'h7FFF_FFFF : nsh[31:0];
    endtask

    task automatic run_vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                           input int hold);
        logic [31:0] e_len, e_lsq;
        logic        e_sat;
        int          lat;
        model(x, y, z, e_len, e_sat, e_lsq);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_x      = x;
        in_y      = y;
        in_z      = z;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x     = $urandom;
        in_y     = $urandom;
        in_z     = $urandom;
        lat      = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd35);
        check("out_len", 64'(out_len), 64'(e_len));
        check("out_sat", 64'(out_sat), 64'(e_sat));
        check("in_ready_busy", 64'(in_ready), 64'd0);
`ifdef VEC3_LEN_SQ_OUT_EN
        check("out_len_sq", 64'(out_len_sq), 64'(e_lsq));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_x     = $urandom;
            in_y     = $urandom;
            in_z     = $urandom;
            @(posedge clk);
            #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_len", 64'(out_len), 64'(e_len));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_back", 64'(in_ready), 64'd1);
        check("len_kept", 64'(out_len), 64'(e_len));
    endtask

    initial begin
        logic [31:0] rx, ry, rz;
        int          seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_len", 64'(out_len), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
`ifdef VEC3_LEN_SQ_OUT_EN
        check("rst_out_len_sq", 64'(out_len_sq), 64'd0);
`endif

        run_vec(32'h0003_0000, 32'h0004_0000, 32'h0000_0000, 0);
        run_vec(32'hFFFD_0000, 32'h0000_0000, 32'hFFFC_0000, 0);
        run_vec(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 0);
        run_vec(32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 0);
        run_vec(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0);
        run_vec(32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 0);
        run_vec(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0);
        run_vec(32'h0002_8000, 32'hFFFF_1234, 32'h0000_0ABC, 10);

        for (int i = 0; i < 10; i++) begin
            rx = $urandom;
            ry = $urandom;
            rz = $urandom;
            if (i % 2 == 0) begin
                rx = 32'($signed(rx) >>> $urandom_range(20, 4));
                ry = 32'($signed(ry) >>> $urandom_range(20, 4));
                rz = 32'($signed(rz) >>> $urandom_range(20, 4));
            end
            run_vec(rx, ry, rz, $urandom_range(2, 0));
        end

        // Abort a vector mid-sqrt with an asynchronous reset.
        @(negedge clk);
        in_x     = 32'h0006_0000;
        in_y     = 32'h0008_0000;
        in_z     = 32'h0000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (23) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_len", 64'(out_len), 64'd0);
        check("abort_out_sat", 64'(out_sat), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_spurious", 64'(seen), 64'd0);
        run_vec(32'h0003_0000, 32'h0004_0000, 32'h0000_0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
